// File: rtl/kernel_control_s_axi_pkg.sv
// Shared register map, CTRL bit positions and channel FSM encodings for the
// kernel control AXI4-Lite slave.
package kernel_control_s_axi_pkg;

    localparam int unsigned ADDR_CTRL     = 32'h00;
    localparam int unsigned ADDR_GIE      = 32'h04;
    localparam int unsigned ADDR_IER      = 32'h08;
    localparam int unsigned ADDR_ISR      = 32'h0C;
    localparam int unsigned ADDR_BUF_BASE = 32'h10;
    localparam int unsigned BUF_STRIDE    = 32'h0C;
    localparam int unsigned BUF_HI_OFFSET = 32'h04;
    localparam int          NUM_BUFFERS   = 10;

    localparam int CTRL_START        = 0;
    localparam int CTRL_DONE         = 1;
    localparam int CTRL_IDLE         = 2;
    localparam int CTRL_READY        = 3;
    localparam int CTRL_CONTINUE     = 4;
    localparam int CTRL_AUTO_RESTART = 7;

    typedef enum logic [1:0] {WRIDLE, WRDATA, WRRESP} wr_state_t;
    typedef enum logic       {RDIDLE, RDDATA}         rd_state_t;

    // Merge only the strobed bytes of a new word into an existing one.
    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                                 input logic [31:0] new_val,
                                                 input logic [3:0]  strb);
        logic [31:0] result;
        result = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) result[8*b +: 8] = new_val[8*b +: 8];
        end
        return result;
    endfunction

endpackage

// File: rtl/kernel_control_s_axi_status.sv
// Sticky kernel status (done/ready) and the GIE/IER/ISR interrupt block.
module kernel_control_s_axi_status
    import kernel_control_s_axi_pkg::*;
(
    input  logic       ap_clk,
    input  logic       ap_rst_n,
    input  logic       ap_done,
    input  logic       ap_ready,
    input  logic       ctrl_read,
    input  logic       gie_write,
    input  logic       ier_write,
    input  logic       isr_write,
    input  logic [1:0] wr_bits,
    output logic       done_sticky,
    output logic       ready_sticky,
    output logic       gie,
    output logic [1:0] ier,
    output logic [1:0] isr,
    output logic       interrupt
);

    logic [1:0] isr_set;

    assign isr_set   = ier & {ap_ready, ap_done};
    assign interrupt = gie & (|isr);

    // A new event wins over the clear-on-read so no completion is ever lost.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            done_sticky  <= 1'b0;
            ready_sticky <= 1'b0;
        end else begin
            if (ap_done)        done_sticky  <= 1'b1;
            else if (ctrl_read) done_sticky  <= 1'b0;
            if (ap_ready)       ready_sticky <= 1'b1;
            else if (ctrl_read) ready_sticky <= 1'b0;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            gie <= 1'b0;
            ier <= 2'b00;
        end else begin
            if (gie_write) gie <= wr_bits[0];
            if (ier_write) ier <= wr_bits;
        end
    end

    // Event set has priority over a concurrent host toggle.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            isr <= 2'b00;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (isr_set[k])                   isr[k] <= 1'b1;
                else if (isr_write && wr_bits[k]) isr[k] <= ~isr[k];
            end
        end
    end

endmodule

// File: rtl/kernel_control_s_axi.sv
// AXI4-Lite control slave driving the kernel ap_ctrl_chain handshake and
// holding the buffer base-address arguments.
module kernel_control_s_axi
    import kernel_control_s_axi_pkg::*;
#(
    parameter int C_S_AXI_ADDR_WIDTH = 12,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int BUFFER_WIDTH_BITS  = 64
) (
    input  logic                          ap_clk,
    input  logic                          ap_rst_n,
    input  logic                          s_axi_control_awvalid,
    output logic                          s_axi_control_awready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] s_axi_control_awaddr,
    input  logic                          s_axi_control_wvalid,
    output logic                          s_axi_control_wready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] s_axi_control_wdata,
    input  logic [3:0]                    s_axi_control_wstrb,
    output logic                          s_axi_control_bvalid,
    input  logic                          s_axi_control_bready,
    output logic [1:0]                    s_axi_control_bresp,
    input  logic                          s_axi_control_arvalid,
    output logic                          s_axi_control_arready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] s_axi_control_araddr,
    output logic                          s_axi_control_rvalid,
    input  logic                          s_axi_control_rready,
    output logic [C_S_AXI_DATA_WIDTH-1:0] s_axi_control_rdata,
    output logic [1:0]                    s_axi_control_rresp,
    output logic                          interrupt,
    output logic                          ap_start,
    output logic                          ap_continue,
    input  logic                          ap_done,
    input  logic                          ap_ready,
    input  logic                          ap_idle,
    output logic [BUFFER_WIDTH_BITS-1:0]  buffer_0,
    output logic [BUFFER_WIDTH_BITS-1:0]  buffer_1,
    output logic [BUFFER_WIDTH_BITS-1:0]  buffer_2,
    output logic [BUFFER_WIDTH_BITS-1:0]  buffer_3,
    output logic [BUFFER_WIDTH_BITS-1:0]  buffer_4,
    output logic [BUFFER_WIDTH_BITS-1:0]  buffer_5,
    output logic [BUFFER_WIDTH_BITS-1:0]  buffer_6,
    output logic [BUFFER_WIDTH_BITS-1:0]  buffer_7,
    output logic [BUFFER_WIDTH_BITS-1:0]  buffer_8,
    output logic [BUFFER_WIDTH_BITS-1:0]  buffer_9
);

    localparam int AW = C_S_AXI_ADDR_WIDTH;
    localparam logic [AW-1:0] A_CTRL = AW'(ADDR_CTRL);
    localparam logic [AW-1:0] A_GIE  = AW'(ADDR_GIE);
    localparam logic [AW-1:0] A_IER  = AW'(ADDR_IER);
    localparam logic [AW-1:0] A_ISR  = AW'(ADDR_ISR);

    function automatic logic [AW-1:0] buf_addr(input int n, input logic hi);
        return AW'(ADDR_BUF_BASE + BUF_STRIDE * n + (hi ? BUF_HI_OFFSET : 0));
    endfunction

    wr_state_t wstate, wnext;
    rd_state_t rstate, rnext;
    logic [AW-1:0] waddr;
    logic          aw_hs, w_hs, ar_hs;
    logic          wr_ctrl, wr_gie, wr_ier, wr_isr, ctrl_read;
    logic          auto_restart, done_sticky, ready_sticky, gie;
    logic [1:0]    ier, isr;
    logic [31:0]   rd_val;
    logic [NUM_BUFFERS-1:0][BUFFER_WIDTH_BITS-1:0] buf_q;

    assign aw_hs = s_axi_control_awvalid & s_axi_control_awready;
    assign w_hs  = s_axi_control_wvalid  & s_axi_control_wready;
    assign ar_hs = s_axi_control_arvalid & s_axi_control_arready;

    assign wr_ctrl   = w_hs && (waddr == A_CTRL) && s_axi_control_wstrb[0];
    assign wr_gie    = w_hs && (waddr == A_GIE)  && s_axi_control_wstrb[0];
    assign wr_ier    = w_hs && (waddr == A_IER)  && s_axi_control_wstrb[0];
    assign wr_isr    = w_hs && (waddr == A_ISR)  && s_axi_control_wstrb[0];
    assign ctrl_read = ar_hs && (s_axi_control_araddr == A_CTRL);

    assign s_axi_control_bresp = 2'b00;
    assign s_axi_control_rresp = 2'b00;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) wstate <= WRIDLE;
        else           wstate <= wnext;
    end

    always_comb begin
        wnext = wstate;
        case (wstate)
            WRIDLE:  if (s_axi_control_awvalid) wnext = WRDATA;
            WRDATA:  if (s_axi_control_wvalid)  wnext = WRRESP;
            WRRESP:  if (s_axi_control_bready)  wnext = WRIDLE;
            default: wnext = WRIDLE;
        endcase
    end

    always_comb begin
        s_axi_control_awready = (wstate == WRIDLE);
        s_axi_control_wready  = (wstate == WRDATA);
        s_axi_control_bvalid  = (wstate == WRRESP);
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) rstate <= RDIDLE;
        else           rstate <= rnext;
    end

    always_comb begin
        rnext = rstate;
        case (rstate)
            RDIDLE:  if (s_axi_control_arvalid) rnext = RDDATA;
            RDDATA:  if (s_axi_control_rready)  rnext = RDIDLE;
            default: rnext = RDIDLE;
        endcase
    end

    always_comb begin
        s_axi_control_arready = (rstate == RDIDLE);
        s_axi_control_rvalid  = (rstate == RDDATA);
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n)  waddr <= '0;
        else if (aw_hs) waddr <= s_axi_control_awaddr;
    end

    // A host start request wins over a same-cycle ap_ready clear.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            ap_start     <= 1'b0;
            ap_continue  <= 1'b0;
            auto_restart <= 1'b0;
        end else begin
            if (wr_ctrl && s_axi_control_wdata[CTRL_START]) ap_start <= 1'b1;
            else if (ap_ready && !auto_restart)             ap_start <= 1'b0;
            ap_continue <= wr_ctrl && s_axi_control_wdata[CTRL_CONTINUE];
            if (wr_ctrl) auto_restart <= s_axi_control_wdata[CTRL_AUTO_RESTART];
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            buf_q <= '0;
        end else if (w_hs) begin
            for (int n = 0; n < NUM_BUFFERS; n++) begin
                if (waddr == buf_addr(n, 1'b0))
                    buf_q[n][31:0] <= apply_wstrb(buf_q[n][31:0], s_axi_control_wdata, s_axi_control_wstrb);
                if (waddr == buf_addr(n, 1'b1))
                    buf_q[n][63:32] <= apply_wstrb(buf_q[n][63:32], s_axi_control_wdata, s_axi_control_wstrb);
            end
        end
    end

    // Unmapped and unaligned addresses fall through to zero.
    always_comb begin
        rd_val = '0;
        if (s_axi_control_araddr == A_CTRL)
            rd_val = {24'b0, auto_restart, 2'b00, 1'b0, ready_sticky, ap_idle, done_sticky, ap_start};
        else if (s_axi_control_araddr == A_GIE) rd_val = {31'b0, gie};
        else if (s_axi_control_araddr == A_IER) rd_val = {30'b0, ier};
        else if (s_axi_control_araddr == A_ISR) rd_val = {30'b0, isr};
        for (int n = 0; n < NUM_BUFFERS; n++) begin
            if (s_axi_control_araddr == buf_addr(n, 1'b0)) rd_val = buf_q[n][31:0];
            if (s_axi_control_araddr == buf_addr(n, 1'b1)) rd_val = buf_q[n][63:32];
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n)  s_axi_control_rdata <= '0;
        else if (ar_hs) s_axi_control_rdata <= rd_val;
    end

    kernel_control_s_axi_status u_status (
        .ap_clk       (ap_clk),
        .ap_rst_n     (ap_rst_n),
        .ap_done      (ap_done),
        .ap_ready     (ap_ready),
        .ctrl_read    (ctrl_read),
        .gie_write    (wr_gie),
        .ier_write    (wr_ier),
        .isr_write    (wr_isr),
        .wr_bits      (s_axi_control_wdata[1:0]),
        .done_sticky  (done_sticky),
        .ready_sticky (ready_sticky),
        .gie          (gie),
        .ier          (ier),
        .isr          (isr),
        .interrupt    (interrupt)
    );

    assign buffer_0 = buf_q[0];
    assign buffer_1 = buf_q[1];
    assign buffer_2 = buf_q[2];
    assign buffer_3 = buf_q[3];
    assign buffer_4 = buf_q[4];
    assign buffer_5 = buf_q[5];
    assign buffer_6 = buf_q[6];
    assign buffer_7 = buf_q[7];
    assign buffer_8 = buf_q[8];
    assign buffer_9 = buf_q[9];

endmodule

// File: tb/tb_kernel_control_s_axi.sv
// Self-checking bench for kernel_control_s_axi: register vectors, handshake
// corner cases and randomized buffer traffic against an address-map model.
module tb_kernel_control_s_axi;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n = 1'b0;
    logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [11:0] awaddr = '0, araddr = '0;
    logic [31:0] wdata = '0, rdata;
    logic [3:0]  wstrb = '0;
    logic [1:0]  bresp, rresp;
    logic        interrupt, ap_start, ap_continue;
    logic        ap_done = 1'b0, ap_ready = 1'b0, ap_idle = 1'b1;
    logic [63:0] buffer_0, buffer_1, buffer_2, buffer_3, buffer_4;
    logic [63:0] buffer_5, buffer_6, buffer_7, buffer_8, buffer_9;

    kernel_control_s_axi dut (
        .ap_clk                (ap_clk),
        .ap_rst_n              (ap_rst_n),
        .s_axi_control_awvalid (awvalid),
        .s_axi_control_awready (awready),
        .s_axi_control_awaddr  (awaddr),
        .s_axi_control_wvalid  (wvalid),
        .s_axi_control_wready  (wready),
        .s_axi_control_wdata   (wdata),
        .s_axi_control_wstrb   (wstrb),
        .s_axi_control_bvalid  (bvalid),
        .s_axi_control_bready  (bready),
        .s_axi_control_bresp   (bresp),
        .s_axi_control_arvalid (arvalid),
        .s_axi_control_arready (arready),
        .s_axi_control_araddr  (araddr),
        .s_axi_control_rvalid  (rvalid),
        .s_axi_control_rready  (rready),
        .s_axi_control_rdata   (rdata),
        .s_axi_control_rresp   (rresp),
        .interrupt             (interrupt),
        .ap_start              (ap_start),
        .ap_continue           (ap_continue),
        .ap_done               (ap_done),
        .ap_ready              (ap_ready),
        .ap_idle               (ap_idle),
        .buffer_0              (buffer_0),
        .buffer_1              (buffer_1),
        .buffer_2              (buffer_2),
        .buffer_3              (buffer_3),
        .buffer_4              (buffer_4),
        .buffer_5              (buffer_5),
        .buffer_6              (buffer_6),
        .buffer_7              (buffer_7),
        .buffer_8              (buffer_8),
        .buffer_9              (buffer_9)
    );

    always #5 ap_clk = ~ap_clk;

    typedef struct {
        logic [11:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_read;
    } vector_t;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] model_buf [10];
    logic        snap_continue, snap_continue_next, snap_interrupt;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    task automatic reportTimeout(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL timeout %s actual=expired expected=handshake", name);
    endtask

    task automatic stepCycle();
        @(posedge ap_clk);
        #1;
    endtask

    function automatic logic [31:0] mergeBytes(input logic [31:0] old_val, input logic [31:0] new_val, input logic [3:0] strb);
        logic [31:0] r;
        r = old_val;
        for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = new_val[8*b +: 8];
        return r;
    endfunction

    // Buffer N occupies two words starting at 0x10 + 12*N; anything else reads 0.
    task automatic modelWrite(input logic [11:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int off, n, r;
        if (addr < 12'h010) return;
        off = int'(addr) - 16;
        n = off / 12;
        r = off % 12;
        if (n < 10 && r == 0) model_buf[n][31:0]  = mergeBytes(model_buf[n][31:0], data, strb);
        if (n < 10 && r == 4) model_buf[n][63:32] = mergeBytes(model_buf[n][63:32], data, strb);
    endtask

    function automatic logic [31:0] modelRead(input logic [11:0] addr);
        int off, n, r;
        if (addr < 12'h010) return 32'h0;
        off = int'(addr) - 16;
        n = off / 12;
        r = off % 12;
        if (n < 10 && r == 0) return model_buf[n][31:0];
        if (n < 10 && r == 4) return model_buf[n][63:32];
        return 32'h0;
    endfunction

    task automatic hostWrite(input logic [11:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input logic done_at_w, input logic ready_at_w);
        int cnt;
        awaddr = addr;
        awvalid = 1'b1;
        cnt = 0;
        while (!awready && cnt < 50) begin stepCycle(); cnt++; end
        if (!awready) reportTimeout("awready");
        stepCycle();
        awvalid = 1'b0;
        wdata = data;
        wstrb = strb;
        wvalid = 1'b1;
        cnt = 0;
        while (!wready && cnt < 50) begin stepCycle(); cnt++; end
        if (!wready) reportTimeout("wready");
        ap_done = done_at_w;
        ap_ready = ready_at_w;
        stepCycle();
        wvalid = 1'b0;
        ap_done = 1'b0;
        ap_ready = 1'b0;
        snap_continue = ap_continue;
        snap_interrupt = interrupt;
        modelWrite(addr, data, strb);
        bready = 1'b1;
        cnt = 0;
        while (!bvalid && cnt < 50) begin stepCycle(); cnt++; end
        if (!bvalid) reportTimeout("bvalid");
        stepCycle();
        bready = 1'b0;
        snap_continue_next = ap_continue;
    endtask

    task automatic hostRead(input logic [11:0] addr, output logic [31:0] data);
        int cnt;
        araddr = addr;
        arvalid = 1'b1;
        cnt = 0;
        while (!arready && cnt < 50) begin stepCycle(); cnt++; end
        if (!arready) reportTimeout("arready");
        stepCycle();
        arvalid = 1'b0;
        rready = 1'b1;
        cnt = 0;
        while (!rvalid && cnt < 50) begin stepCycle(); cnt++; end
        if (!rvalid) reportTimeout("rvalid");
        data = rdata;
        stepCycle();
        rready = 1'b0;
    endtask

    task automatic pulseReady();
        ap_ready = 1'b1;
        stepCycle();
        ap_ready = 1'b0;
    endtask

    task automatic pulseDone();
        ap_done = 1'b1;
        stepCycle();
        ap_done = 1'b0;
    endtask

    task automatic applyStimulus(input vector_t v);
        logic [31:0] rd;
        hostWrite(v.addr, v.data, v.strb, 1'b0, 1'b0);
        hostRead(v.addr, rd);
        checkOutput($sformatf("vector@%h", v.addr), {32'h0, rd}, {32'h0, v.exp_read});
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vector_t     vecs [11];
        logic [31:0] rd;
        logic [11:0] a;
        int          held, cnt;

        vecs[0]  = '{12'h010, 32'hDEADBEEF, 4'hF, 32'hDEADBEEF};
        vecs[1]  = '{12'h014, 32'h00000001, 4'hF, 32'h00000001};
        vecs[2]  = '{12'h010, 32'h00000012, 4'h1, 32'hDEADBE12};
        vecs[3]  = '{12'h07C, 32'h12345678, 4'hF, 32'h12345678};
        vecs[4]  = '{12'h080, 32'hCAFEF00D, 4'hC, 32'hCAFE0000};
        vecs[5]  = '{12'h018, 32'hFFFFFFFF, 4'hF, 32'h00000000};
        vecs[6]  = '{12'h200, 32'h0000AAAA, 4'hF, 32'h00000000};
        vecs[7]  = '{12'h008, 32'h00000003, 4'hF, 32'h00000003};
        vecs[8]  = '{12'h008, 32'h000000FF, 4'h0, 32'h00000003};
        vecs[9]  = '{12'h008, 32'h00000000, 4'hF, 32'h00000000};
        vecs[10] = '{12'h004, 32'h00000000, 4'hF, 32'h00000000};
        for (int i = 0; i < 10; i++) model_buf[i] = '0;

        $display("[TB] reset");
        #23 ap_rst_n = 1'b1;
        stepCycle();
        checkOutput("reset_awready", awready, 1);
        checkOutput("reset_arready", arready, 1);
        checkOutput("reset_wready", wready, 0);
        checkOutput("reset_bvalid", bvalid, 0);
        checkOutput("reset_rvalid", rvalid, 0);
        checkOutput("reset_ap_start", ap_start, 0);
        checkOutput("reset_ap_continue", ap_continue, 0);
        checkOutput("reset_interrupt", interrupt, 0);
        checkOutput("reset_rdata", rdata, 0);
        checkOutput("reset_buffers", buffer_0 | buffer_1 | buffer_2 | buffer_3 | buffer_4 |
                    buffer_5 | buffer_6 | buffer_7 | buffer_8 | buffer_9, 0);
        hostRead(12'h000, rd);
        checkOutput("reset_ctrl_read", rd, 32'h4);

        $display("[TB] register vectors");
        for (int i = 0; i < 11; i++) applyStimulus(vecs[i]);
        checkOutput("buffer_0_port", buffer_0, 64'h1_DEADBE12);
        checkOutput("buffer_9_port", buffer_9, 64'hCAFE0000_12345678);

        $display("[TB] start and ready");
        hostWrite(12'h000, 32'h1, 4'hF, 1'b0, 1'b0);
        checkOutput("start_set", ap_start, 1);
        repeat (5) stepCycle();
        pulseReady();
        checkOutput("start_cleared_by_ready", ap_start, 0);
        hostRead(12'h000, rd);
        checkOutput("ctrl_ready_sticky", rd, 32'h0C);
        hostRead(12'h000, rd);
        checkOutput("ctrl_ready_cleared", rd, 32'h04);

        $display("[TB] interrupt");
        hostWrite(12'h004, 32'h1, 4'hF, 1'b0, 1'b0);
        hostWrite(12'h008, 32'h1, 4'hF, 1'b0, 1'b0);
        checkOutput("irq_before_done", interrupt, 0);
        pulseDone();
        checkOutput("irq_after_done", interrupt, 1);
        hostRead(12'h00C, rd);
        checkOutput("isr_after_done", rd, 32'h1);
        hostWrite(12'h00C, 32'h1, 4'hF, 1'b0, 1'b0);
        checkOutput("irq_after_isr_toggle", snap_interrupt, 0);
        hostRead(12'h000, rd);
        checkOutput("ctrl_done_sticky", rd, 32'h06);

        $display("[TB] continue and auto restart");
        hostWrite(12'h000, 32'h1, 4'hF, 1'b0, 1'b0);
        hostWrite(12'h000, 32'h10, 4'hF, 1'b0, 1'b0);
        checkOutput("continue_pulse", snap_continue, 1);
        checkOutput("continue_one_cycle", snap_continue_next, 0);
        checkOutput("start_kept_on_zero_write", ap_start, 1);
        hostWrite(12'h000, 32'h81, 4'hF, 1'b0, 1'b0);
        pulseReady();
        checkOutput("auto_restart_keeps_start", ap_start, 1);
        hostRead(12'h000, rd);
        checkOutput("ctrl_auto_restart", rd, 32'h8D);
        hostWrite(12'h000, 32'h00, 4'hF, 1'b0, 1'b0);
        checkOutput("start_after_auto_off", ap_start, 1);
        pulseReady();
        checkOutput("start_cleared_auto_off", ap_start, 0);
        hostRead(12'h000, rd);
        checkOutput("ctrl_after_auto_off", rd, 32'h0C);

        $display("[TB] simultaneous events");
        araddr = 12'h000;
        arvalid = 1'b1;
        ap_done = 1'b1;
        stepCycle();
        arvalid = 1'b0;
        ap_done = 1'b0;
        rready = 1'b1;
        checkOutput("coincident_rvalid", rvalid, 1);
        checkOutput("coincident_read_pre_event", rdata, 32'h04);
        stepCycle();
        rready = 1'b0;
        hostRead(12'h000, rd);
        checkOutput("coincident_done_kept", rd, 32'h06);
        hostWrite(12'h000, 32'h1, 4'hF, 1'b0, 1'b1);
        checkOutput("start_wins_over_ready", ap_start, 1);
        pulseReady();
        hostWrite(12'h00C, 32'h1, 4'hF, 1'b1, 1'b0);
        hostRead(12'h00C, rd);
        checkOutput("isr_event_wins_toggle", rd, 32'h1);
        checkOutput("irq_event_wins_toggle", interrupt, 1);
        hostWrite(12'h00C, 32'h1, 4'hF, 1'b0, 1'b0);
        checkOutput("irq_cleared", snap_interrupt, 0);

        $display("[TB] write response backpressure");
        awaddr = 12'h01C;
        awvalid = 1'b1;
        cnt = 0;
        while (!awready && cnt < 50) begin stepCycle(); cnt++; end
        stepCycle();
        awvalid = 1'b0;
        wdata = 32'h0BADF00D;
        wstrb = 4'hF;
        wvalid = 1'b1;
        cnt = 0;
        while (!wready && cnt < 50) begin stepCycle(); cnt++; end
        stepCycle();
        wvalid = 1'b0;
        modelWrite(12'h01C, 32'h0BADF00D, 4'hF);
        held = 0;
        for (int i = 0; i < 10; i++) begin
            if (bvalid) held++;
            stepCycle();
        end
        checkOutput("bvalid_held", held, 10);
        bready = 1'b1;
        stepCycle();
        bready = 1'b0;
        checkOutput("bvalid_released", bvalid, 0);
        checkOutput("buffer_1_low", buffer_1[31:0], 32'h0BADF00D);

        $display("[TB] randomized buffer traffic");
        for (int i = 0; i < 40; i++) begin
            a = 12'h010 + 12'(4 * $urandom_range(0, 59));
            hostWrite(a, $urandom, 4'($urandom_range(0, 15)), 1'b0, 1'b0);
            a = 12'h010 + 12'(4 * $urandom_range(0, 59));
            hostRead(a, rd);
            checkOutput($sformatf("random_read@%h", a), rd, modelRead(a));
        end
        checkOutput("random_buffer_0", buffer_0, model_buf[0]);
        checkOutput("random_buffer_1", buffer_1, model_buf[1]);
        checkOutput("random_buffer_2", buffer_2, model_buf[2]);
        checkOutput("random_buffer_3", buffer_3, model_buf[3]);
        checkOutput("random_buffer_4", buffer_4, model_buf[4]);
        checkOutput("random_buffer_5", buffer_5, model_buf[5]);
        checkOutput("random_buffer_6", buffer_6, model_buf[6]);
        checkOutput("random_buffer_7", buffer_7, model_buf[7]);
        checkOutput("random_buffer_8", buffer_8, model_buf[8]);
        checkOutput("random_buffer_9", buffer_9, model_buf[9]);

        $display("[TB] reset mid-read");
        araddr = 12'h010;
        arvalid = 1'b1;
        stepCycle();
        arvalid = 1'b0;
        checkOutput("rvalid_before_reset", rvalid, 1);
        #2 ap_rst_n = 1'b0;
        #1;
        checkOutput("rvalid_async_reset", rvalid, 0);
        checkOutput("buffer_0_async_reset", buffer_0, 0);
        for (int i = 0; i < 10; i++) model_buf[i] = '0;
        repeat (2) @(posedge ap_clk);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        stepCycle();
        checkOutput("arready_after_reset", arready, 1);
        checkOutput("rvalid_after_reset", rvalid, 0);
        checkOutput("rdata_after_reset", rdata, 0);
        hostRead(12'h010, rd);
        checkOutput("buffer_read_after_reset", rd, modelRead(12'h010));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/kernel_control_s_axi.md
# kernel_control_s_axi

AXI4-Lite control slave that acts as the host-facing initiator of the kernel's ap_ctrl_chain handshake. It decodes register writes into ap_start/ap_continue pulses and buffer base-address arguments, and it latches the kernel's ap_done/ap_ready/ap_idle status for host polling and interrupt generation. It sits between the platform shell's control port and the kernel AFU top.

## Interface
- C_S_AXI_ADDR_WIDTH, 12, control address width (byte address)
- C_S_AXI_DATA_WIDTH, 32, control data width; only 32 is supported
- BUFFER_WIDTH_BITS, 64, width of each buffer_N argument
- ap_clk  in  1  single clock; all logic on rising edge
- ap_rst_n  in  1  asynchronous, active-low reset
- s_axi_control_awvalid/awready  in/out  1  write address handshake; awaddr  in  C_S_AXI_ADDR_WIDTH
- s_axi_control_wvalid/wready  in/out  1  write data handshake; wdata  in  32; wstrb  in  4
- s_axi_control_bvalid/bready  out/in  1  write response; bresp  out  2  (always 2'b00)
- s_axi_control_arvalid/arready  in/out  1  read address handshake; araddr  in  C_S_AXI_ADDR_WIDTH
- s_axi_control_rvalid/rready  out/in  1  read data; rdata  out  32; rresp  out  2  (always 2'b00)
- interrupt  out  1  level interrupt = GIE & |ISR
- ap_start  out  1  kernel start request
- ap_continue  out  1  one-cycle acknowledge of ap_done
- ap_done, ap_ready, ap_idle  in  1  kernel status
- buffer_0 … buffer_9  out  BUFFER_WIDTH_BITS  kernel argument registers

## Operation
- Register map:
  - 0x00 CTRL: bit0 ap_start (R/W, set-only by host); bit1 ap_done (RO, clear-on-read); bit2 ap_idle (RO, live); bit3 ap_ready (RO, clear-on-read); bit4 ap_continue (W, self-clearing); bit7 auto_restart (R/W).
  - 0x04 GIE: bit0.
  - 0x08 IER: bit0 done enable, bit1 ready enable.
  - 0x0C ISR: bits1:0 are toggle-on-write-1.
  - 0x10 + 0x0C·N: buffer_N low word; +0x04: buffer_N high word; N = 0..9, ending at 0x7C.
- Write FSM states:
  - WRIDLE: awready=1; capture awaddr on awvalid → WRDATA.
  - WRDATA: wready=1; on wvalid, apply wdata under wstrb byte mask → WRRESP.
  - WRRESP: bvalid=1; hold until bready → WRIDLE.
- Read FSM states:
  - RDIDLE: arready=1; on arvalid, register rdata from the decoded register → RDDATA.
  - RDDATA: rvalid=1; rdata stable until rready → RDIDLE.
- ap_start:
  - Set when the host writes 1 to CTRL bit0 (byte 0 strobed).
  - Cleared on the cycle ap_ready is high unless auto_restart=1.
  - A host write of 0 has no effect.
- ap_continue: high for exactly one cycle after a CTRL write with bit4=1; never held.
- Sticky status: done_sticky is set on ap_done=1 and cleared on the CTRL read handshake (arvalid&arready, addr 0x00). ready_sticky behaves the same with ap_ready.
- ISR bit k is set when IER bit k=1 and its event pulses.
- Unmapped address: reads return 0, writes are ignored, response OKAY.

## Timing
- Reset values: all registers 0. awready=arready=1 one cycle after release. wready, bvalid, rvalid, ap_start, ap_continue, interrupt are 0. rdata=0. buffer_N=0.
- Write latency: AW accept at cycle t, W accept at t+1 at the earliest, bvalid at t+2. The register update is visible on outputs the cycle after W accept.
- Read latency: rvalid the cycle after the AR handshake.
- Simultaneous events:
  - An ap_done pulse in the same cycle as a CTRL clear-on-read leaves done_sticky=1; the read returns the pre-event value.
  - A host start write in the same cycle as ap_ready leaves ap_start=1.
  - A concurrent ISR toggle and event set leaves the ISR bit at 1.
- Read and write channels are independent and may complete in the same cycle.
- Reset asserted mid-transaction: FSMs return to idle immediately; a pending bvalid/rvalid is dropped.

## Structure
- Shared package: register offset localparams, CTRL bit-index constants, and write/read FSM state enums.
- One sub-module is natural: kernel_control_s_axi_status, holding the sticky done/ready, ISR/IER/GIE and interrupt logic.

## Test plan
- Reset release → read 0x00 returns 0x00000004 with ap_idle=1; interrupt=0; all buffer_N=0.
- Write 0x10=0xDEAD_BEEF, 0x14=0x0000_0001 → buffer_0=0x1_DEADBEEF; wstrb=4'b0001 write of 0x12 to 0x10 → buffer_0=0x1_DEADBE12.
- Write CTRL=0x1; pulse ap_ready 5 cycles later → ap_start falls the same edge; read CTRL → bit3=1, a second read → bit3=0.
- GIE=1, IER=0x1; pulse ap_done → interrupt=1, ISR=0x1; write ISR=0x1 → interrupt=0 next cycle.
- CTRL write 0x10 → ap_continue high exactly 1 cycle; auto_restart=1 with ap_ready pulse → ap_start stays 1.
- bready held low 10 cycles → bvalid held; ap_rst_n dropped mid-read → rvalid=0 asynchronously, arready=1 after release.
